// File: rtl/operand_bank_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bank_writer_pkg
//  Description : Shared constants and helpers for the operand bank writer:
//                bank geometry, source-code encoding for commit tracing and
//                a slicing helper for the flat per-requester buses.
//  Revision    : 1.0  initial release
// ============================================================================
package operand_bank_writer_pkg;

    // Bank geometry: eight operand entries addressed by a 3-bit index.
    localparam int NREG  = 8;
    localparam int SEL_W = 3;

    // Value of the commit_src MSB when the write came from the external load
    // port; the low bits are then zero.
    localparam logic SRC_LOAD = 1'b1;

    // Upper bounds for the generic slicing helper. Any flat bus handed to
    // slice_field must fit in MAX_BUS_W bits and any field in MAX_FIELD_W.
    localparam int MAX_BUS_W   = 4096;
    localparam int MAX_FIELD_W = 256;

    // Extract field number idx (each field_w bits wide, field 0 at the LSB)
    // from a flat bus. The caller truncates the result to the field width.
    function automatic logic [MAX_FIELD_W-1:0] slice_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          field_w
    );
        return MAX_FIELD_W'(bus >> (idx * field_w));
    endfunction

endpackage : operand_bank_writer_pkg
`default_nettype wire

// File: rtl/operand_bank_writer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first asserted
//                request at or after the pointer, wrapping modulo NREQ. The
//                pointer register is owned by the instantiating module.
//  Ports       : i_req      request vector, one bit per requester
//                i_ptr      index of the highest-priority requester
//                i_en       when low no grant is issued
//                o_gnt      one-hot grant (or zero)
//                o_gnt_idx  binary index of the granted requester
//                o_any_gnt  a grant was issued
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any_gnt
);

    // One extra bit so ptr + offset can be formed before the wrap.
    localparam logic [IDX_W:0] c_nreq = (IDX_W+1)'(NREQ);

    logic [IDX_W:0] w_cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any_gnt = 1'b0;
        w_cand    = '0;
        if (i_en) begin
            for (int k = 0; k < NREQ; k++) begin
                w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
                if (w_cand >= c_nreq) begin
                    w_cand = w_cand - c_nreq;
                end
                if (!o_any_gnt && i_req[w_cand[IDX_W-1:0]]) begin
                    o_gnt[w_cand[IDX_W-1:0]] = 1'b1;
                    o_gnt_idx                = w_cand[IDX_W-1:0];
                    o_any_gnt                = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/operand_bank_writer.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bank_writer
//  Description : Write-back end of the cell operand network. Owns the 8-entry
//                operand bank feeding in0..in7 of every compute cell, accepts
//                results from NREQ cells plus one external load port and
//                commits at most one write per cycle, reporting each commit.
//  Ports       : clk, reset            clock / synchronous active-high reset
//                ld_valid/dest/data    external load, always accepted
//                wr_valid/dest/data    per-cell result requests (flat buses)
//                wr_ready              per-cell grant, combinational
//                out0..out7            registered bank entries
//                commit_valid/dest/src registered record of the last commit
//  Revision    : 1.0  initial release
// ============================================================================
module operand_bank_writer
    import operand_bank_writer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_valid,
    input  logic [2:0]                 ld_dest,
    input  logic [WIDTH-1:0]           ld_data,
    input  logic [NREQ-1:0]            wr_valid,
    input  logic [3*NREQ-1:0]          wr_dest,
    input  logic [WIDTH*NREQ-1:0]      wr_data,
    output logic [NREQ-1:0]            wr_ready,
    output logic [WIDTH-1:0]           out0,
    output logic [WIDTH-1:0]           out1,
    output logic [WIDTH-1:0]           out2,
    output logic [WIDTH-1:0]           out3,
    output logic [WIDTH-1:0]           out4,
    output logic [WIDTH-1:0]           out5,
    output logic [WIDTH-1:0]           out6,
    output logic [WIDTH-1:0]           out7,
    output logic                       commit_valid,
    output logic [2:0]                 commit_dest,
    output logic [$clog2(NREQ):0]      commit_src
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int SRC_W = IDX_W + 1;

    // ------------------------------------------------------------------
    // Unpack the flat request buses into per-requester arrays
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_req_dest [NREQ];
    logic [WIDTH-1:0] w_req_data [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req_dest[gi] = SEL_W'(slice_field(MAX_BUS_W'(wr_dest), gi, SEL_W));
        assign w_req_data[gi] = WIDTH'(slice_field(MAX_BUS_W'(wr_data), gi, WIDTH));
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bank_q [NREG];
    logic [WIDTH-1:0] bank_d [NREG];
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             commit_valid_q;
    logic             commit_valid_d;
    logic [SEL_W-1:0] commit_dest_q;
    logic [SEL_W-1:0] commit_dest_d;
    logic [SRC_W-1:0] commit_src_q;
    logic [SRC_W-1:0] commit_src_d;

    // ------------------------------------------------------------------
    // Cell arbitration. A pending external load (or reset) suppresses all
    // cell grants; wr_ready depends only on inputs and the pointer.
    // ------------------------------------------------------------------
    logic             w_arb_en;
    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_any_grant;

    assign w_arb_en = !reset && !ld_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req     (wr_valid),
        .i_ptr     (ptr_q),
        .i_en      (w_arb_en),
        .o_gnt     (w_grant),
        .o_gnt_idx (w_grant_idx),
        .o_any_gnt (w_any_grant)
    );

    assign wr_ready = w_grant;

    // ------------------------------------------------------------------
    // Write selection and next-state
    // ------------------------------------------------------------------
    always_comb begin
        bank_d         = bank_q;
        ptr_d          = ptr_q;
        commit_valid_d = 1'b0;
        commit_dest_d  = commit_dest_q;
        commit_src_d   = commit_src_q;

        if (ld_valid) begin
            bank_d[ld_dest] = ld_data;
            commit_valid_d  = 1'b1;
            commit_dest_d   = ld_dest;
            commit_src_d    = {SRC_LOAD, IDX_W'(0)};
        end else if (w_any_grant) begin
            bank_d[w_req_dest[w_grant_idx]] = w_req_data[w_grant_idx];
            commit_valid_d = 1'b1;
            commit_dest_d  = w_req_dest[w_grant_idx];
            commit_src_d   = {1'b0, w_grant_idx};
            // Granted requester drops to lowest priority next time round.
            if (w_grant_idx == IDX_W'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_grant_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                bank_q[r] <= '0;
            end
            ptr_q          <= '0;
            commit_valid_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_src_q   <= '0;
        end else begin
            bank_q         <= bank_d;
            ptr_q          <= ptr_d;
            commit_valid_q <= commit_valid_d;
            commit_dest_q  <= commit_dest_d;
            commit_src_q   <= commit_src_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out0         = bank_q[0];
    assign out1         = bank_q[1];
    assign out2         = bank_q[2];
    assign out3         = bank_q[3];
    assign out4         = bank_q[4];
    assign out5         = bank_q[5];
    assign out6         = bank_q[6];
    assign out7         = bank_q[7];
    assign commit_valid = commit_valid_q;
    assign commit_dest  = commit_dest_q;
    assign commit_src   = commit_src_q;

endmodule : operand_bank_writer
`default_nettype wire
